// File: rtl/fpu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fpu_arbiter_pkg
// Shared FPU definitions used by the arbiter and anything else that talks to
// the shared fpu datapath: datapath width, default latency and the opcode set.
// ---------------------------------------------------------------------------
package fpu_arbiter_pkg;

  localparam int FPU_W           = 32;
  localparam int FPU_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    FPU_OP_ADD = 2'b00,
    FPU_OP_SUB = 2'b01,
    FPU_OP_DIV = 2'b10,
    FPU_OP_MUL = 2'b11
  } fpu_op_e;

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin priority select over NUM_REQ requests. The search starts at the
// internal pointer and wraps; the winner gets a one-hot grant and the pointer
// moves to the slot just after the winner so it has lowest priority next time.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   en         : 0 forces no grant and freezes the pointer
//   req        : request vector
//   gnt        : one-hot grant, or zero
//   gnt_id     : binary index of the granted request (0 when no grant)
//   gnt_any    : a grant is issued this cycle
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;

  // NOTE: every output of a combinational block gets a default before any
  // conditional logic, so no path leaves a variable unassigned (no latch).
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && req[(int'(ptr) + k) % NUM_REQ]) begin
          gnt_any                          = 1'b1;
          gnt[(int'(ptr) + k) % NUM_REQ]   = 1'b1;
          gnt_id                           = ID_W'((int'(ptr) + k) % NUM_REQ);
        end
      end
    end
    ptr_nxt = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter
// Shares one fixed-latency fpu between NUM_REQ scalar issue units. Each cycle
// at most one valid request is granted (round-robin), its operands/opcode are
// registered onto the fpu inputs, and its id travels down a FPU_LAT-deep tag
// pipeline that lines up with the fpu result. Results leave on one broadcast
// response bus tagged with the originating id; there is no backpressure.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester valid / one-hot grant
//   req_a, req_b, req_op: packed per-requester operands and opcode
//   hold                : 1 = no new grants, in-flight ops still drain
//   fpu_a, fpu_b, fpu_op: registered fpu inputs
//   fpu_o               : fpu result
//   rsp_valid/id/data   : one-cycle response pulse, id and result
//   idle                : nothing in flight and no grant this cycle
// ---------------------------------------------------------------------------
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = FPU_LAT_DEFAULT,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [FPU_W*NUM_REQ-1:0] req_a,
  input  logic [FPU_W*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic                     hold,
  output logic [FPU_W-1:0]         fpu_a,
  output logic [FPU_W-1:0]         fpu_b,
  output logic [1:0]               fpu_op,
  input  logic [FPU_W-1:0]         fpu_o,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [FPU_W-1:0]         rsp_data,
  output logic                     idle
);

  // Holds 0..FPU_LAT+1 outstanding operations.
  localparam int CNT_W = $clog2(FPU_LAT + 2);

  logic [NUM_REQ-1:0]           gnt;
  logic [ID_W-1:0]              gnt_id;
  logic                         accept;
  logic                         launch;
  logic [FPU_LAT-1:0]           tag_vld;
  logic [FPU_LAT-1:0][ID_W-1:0] tag_id;
  logic [CNT_W-1:0]             inflight;

  // Gating with rst_n keeps req_ready low for the whole reset assertion, not
  // just from the first clock edge.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (~hold & rst_n),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (accept)
  );

  assign req_ready = gnt;
  assign launch    = tag_vld[FPU_LAT-1];
  assign idle      = (inflight == '0) & ~|req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      tag_vld   <= '0;
      tag_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
    end else begin
      // fpu inputs keep their last value when nothing is accepted.
      if (accept) begin
        fpu_a  <= req_a[int'(gnt_id)*FPU_W +: FPU_W];
        fpu_b  <= req_b[int'(gnt_id)*FPU_W +: FPU_W];
        fpu_op <= req_op[int'(gnt_id)*2 +: 2];
      end

      // Tag pipeline never stalls; the id of an empty slot is don't-care.
      tag_vld[0] <= accept;
      tag_id[0]  <= gnt_id;
      for (int i = 1; i < FPU_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end

      // Last tag stage lines up with fpu_o for that operation.
      rsp_valid <= launch;
      if (launch) begin
        rsp_id   <= tag_id[FPU_LAT-1];
        rsp_data <= fpu_o;
      end

      unique case ({accept, launch})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
module tb_fpu_arbiter;
  import fpu_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;

  localparam logic [31:0] A0 = 32'h3D11B19E;
  localparam logic [31:0] B0 = 32'h49B39439;
  localparam logic [31:0] P0 = 32'h474C6719;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [2*N-1:0] req_op;
  logic          hold;
  logic [31:0]   fpu_a, fpu_b, fpu_o;
  logic [1:0]    fpu_op;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [31:0]   rsp_data;
  logic          idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.NUM_REQ(N), .FPU_LAT(LAT), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .hold(hold),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_o(fpu_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .idle(idle)
  );

  // Stand-in fpu: one known multiply vector, otherwise a simple sum.
  // Combinational function plus LAT-1 register stages gives latency LAT.
  function automatic logic [31:0] fpu_f(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    if (a == A0 && b == B0 && op == FPU_OP_MUL) return P0;
    return a + b + {30'd0, op};
  endfunction

  logic [31:0] fpu_pipe;
  always @(posedge clk) fpu_pipe <= fpu_f(fpu_a, fpu_b, fpu_op);
  assign fpu_o = fpu_pipe;

  function automatic logic [31:0] a_of(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0111;
  endfunction
  function automatic logic [31:0] b_of(int i);
    return 32'h0000_0100 * 32'(i + 1);
  endfunction
  function automatic logic [1:0] op_of(int i);
    return 2'(i);
  endfunction
  function automatic logic [31:0] exp_data(int i);
    return fpu_f(a_of(i), b_of(i), op_of(i));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic          hold;
    logic [N-1:0]  ready;
    logic          rv;
    logic [IW-1:0] id;
    logic          idle;
  } row_t;

  localparam int NROWS = 24;
  row_t tbl [NROWS];

  initial begin
    // Rows are applied one per cycle starting from ptr=0 after reset.
    // Each row's expected registered outputs reflect all earlier edges.
    tbl[0]  = '{4'hF, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'hF, 1'b0, 4'h4, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 4'h8, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0};
    tbl[6]  = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1};
    tbl[7]  = '{4'h4, 1'b0, 4'h4, 1'b0, 2'd3, 1'b0};
    tbl[8]  = '{4'h9, 1'b0, 4'h8, 1'b0, 2'd3, 1'b0};
    tbl[9]  = '{4'h9, 1'b0, 4'h1, 1'b0, 2'd3, 1'b0};
    tbl[10] = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0};
    tbl[11] = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0};
    tbl[12] = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1};
    tbl[13] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1};
    tbl[14] = '{4'hF, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{4'hF, 1'b0, 4'h4, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1'b0};
    tbl[18] = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1};
    tbl[19] = '{4'hF, 1'b1, 4'h0, 1'b0, 2'd2, 1'b1};
    tbl[20] = '{4'hF, 1'b0, 4'h8, 1'b0, 2'd2, 1'b0};
    tbl[21] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0};
    tbl[22] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0};
    tbl[23] = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1};

    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_of(i);
      req_b[32*i +: 32] = b_of(i);
      req_op[2*i +: 2]  = op_of(i);
    end

    // Reset state, with requests pending.
    #2 req_valid = 4'hF;
    #1;
    check("reset req_ready", 32'(req_ready), 32'h0);
    check("reset idle", 32'(idle), 32'h1);
    check("reset fpu_a", fpu_a, 32'h0);
    check("reset fpu_b", fpu_b, 32'h0);
    check("reset fpu_op", 32'(fpu_op), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_id", 32'(rsp_id), 32'h0);
    check("reset rsp_data", rsp_data, 32'h0);
    req_valid = '0;
    #5 rst_n = 1'b1;

    // Table: continuous round-robin, fairness, hold/drain/resume.
    for (int k = 0; k < NROWS; k++) begin
      @(posedge clk); #1;
      req_valid = tbl[k].valid;
      hold      = tbl[k].hold;
      #1;
      check($sformatf("row%0d req_ready", k), 32'(req_ready), 32'(tbl[k].ready));
      check($sformatf("row%0d onehot", k), 32'($countones(req_ready) <= 1), 32'h1);
      check($sformatf("row%0d rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].rv));
      check($sformatf("row%0d rsp_id", k), 32'(rsp_id), 32'(tbl[k].id));
      check($sformatf("row%0d idle", k), 32'(idle), 32'(tbl[k].idle));
      if (tbl[k].rv)
        check($sformatf("row%0d rsp_data", k), rsp_data, exp_data(int'(tbl[k].id)));
    end

    // Single multiply from requester 1 (ptr is 0 here).
    @(posedge clk); #1;
    req_a[32 +: 32] = A0;
    req_b[32 +: 32] = B0;
    req_op[2 +: 2]  = FPU_OP_MUL;
    req_valid       = 4'h2;
    #1;
    check("mul req_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;                     // E0
    req_valid = '0;
    #1;
    check("mul fpu_a", fpu_a, A0);
    check("mul fpu_b", fpu_b, B0);
    check("mul fpu_op", 32'(fpu_op), 32'(FPU_OP_MUL));
    check("mul busy", 32'(idle), 32'h0);
    @(posedge clk); #2;                     // E0+1
    check("mul early rsp", 32'(rsp_valid), 32'h0);
    @(posedge clk); #2;                     // E0+2
    check("mul rsp_valid", 32'(rsp_valid), 32'h1);
    check("mul rsp_id", 32'(rsp_id), 32'h1);
    check("mul rsp_data", rsp_data, P0);
    check("mul idle", 32'(idle), 32'h1);
    @(posedge clk); #2;
    check("mul rsp pulse", 32'(rsp_valid), 32'h0);
    req_a[32 +: 32] = a_of(1);
    req_b[32 +: 32] = b_of(1);
    req_op[2 +: 2]  = op_of(1);

    // Reset with three ops accepted (ptr 2 -> accepts 2, 3, 0).
    @(posedge clk); #1;
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst req_ready", 32'(req_ready), 32'h0);
    check("arst idle", 32'(idle), 32'h1);
    check("arst fpu_a", fpu_a, 32'h0);
    check("arst rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst rsp_id", 32'(rsp_id), 32'h0);
    check("arst rsp_data", rsp_data, 32'h0);
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      check($sformatf("post-reset quiet%0d", c), 32'(rsp_valid), 32'h0);
      check($sformatf("post-reset idle%0d", c), 32'(idle), 32'h1);
    end
    // Pointer back at 0: requesters 0 and 3 valid -> 0 wins.
    @(posedge clk); #1;
    req_valid = 4'h9;
    #1;
    check("post-reset ptr", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #2;
    check("post-reset rsp_valid", 32'(rsp_valid), 32'h1);
    check("post-reset rsp_id", 32'(rsp_id), 32'h0);
    check("post-reset rsp_data", rsp_data, exp_data(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
